fifo_rr_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter in front of the single-clock FIFO. It shares one FIFO write port among NUM_REQ producers.
- Grants one producer at a time for a burst of up to BURST_LEN words.
- Gates the FIFO write strobe with fifo_full, so the FIFO never sees a write while full. The FIFO itself has no overflow protection.
- Sits between producer blocks and the FIFO's w/data_in/full pins.

---
 rtl/fifo_rr_wr_arbiter_pkg.sv | 31 +++
 rtl/fifo_rr_wr_arbiter_rr_select.sv | 43 ++++
 rtl/fifo_rr_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fifo_rr_wr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared definitions for the round-robin FIFO write arbiter:
//            FSM state encodings, statistics counter width and a
//            constant-evaluable clog2 helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int STAT_WIDTH = 16;

    // Ceiling log2. clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rr_wr_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Purpose  : Combinational round-robin picker. Scans req starting at
//            rr_last+1 (wrapping modulo NUM_REQ) and reports the first set
//            index.
// Ports    : req    [NUM_REQ] - request vector
//            rr_last[IDX_W]   - index granted most recently
//            found            - at least one request is set
//            winner [IDX_W]   - selected index (0 when found is low)
// Revision : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_last,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    // Walk offsets from farthest to nearest so the nearest set request
    // after rr_last is the last assignment and therefore the winner.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = int'(rr_last) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[IDX_W'(idx)]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_wr_arbiter
// Purpose  : Shares one FIFO write port among NUM_REQ producers. A producer
//            is granted for a burst of up to BURST_LEN words; writes are
//            suppressed while fifo_full is high. One idle cycle separates
//            consecutive grants.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_data/req_last - per-requester word interface
//            req_ready                   - one-hot-or-zero accept
//            fifo_full, fifo_w, fifo_data - FIFO write side
//            grant_id, busy              - current owner / in GRANT
//            stat_words (FIFO_ARB_STATS_EN only) - per-requester word counts
// Config   : define FIFO_ARB_STATS_EN to add saturating word counters.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [clog2(NUM_REQ)-1:0]     grant_id,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*STAT_WIDTH-1:0] stat_words,
`endif
    output logic                          busy
);

    localparam int c_idx_w = clog2(NUM_REQ);
    localparam int c_cnt_w = clog2(BURST_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    logic [0:0]         state_q,    state_d;
    logic [c_idx_w-1:0] owner_q,    owner_d;
    logic [c_idx_w-1:0] rr_last_q,  rr_last_d;
    logic [c_cnt_w-1:0] beat_cnt_q, beat_cnt_d;

    logic               w_found;
    logic [c_idx_w-1:0] w_winner;
    logic               w_in_grant;
    logic               w_own_valid;
    logic               w_own_last;
    logic               w_accept;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_select (
        .req     (req_valid),
        .rr_last (rr_last_q),
        .found   (w_found),
        .winner  (w_winner)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_last_q  <= c_idx_w'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    owner_d    = w_winner;
                    rr_last_d  = w_winner;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_accept) begin
                    if (beat_cnt_q == c_last_beat || w_own_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + c_one;
                    end
                end else if (!w_own_valid) begin
                    // Producer abandoned the burst.
                    state_d = ST_IDLE;
                end
                // valid & full: stall, everything held.
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: owner's lanes are selected with constant-index slices.
    always_comb begin
        w_in_grant  = (state_q == ST_GRANT);
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        fifo_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == c_idx_w'(i)) begin
                w_own_valid = req_valid[i];
                w_own_last  = req_last[i];
                if (w_in_grant) begin
                    fifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        w_accept  = w_in_grant & w_own_valid & ~fifo_full;
        fifo_w    = w_accept;
        req_ready = w_accept ? (NUM_REQ'(1) << owner_q) : '0;
        grant_id  = owner_q;
        busy      = w_in_grant;
    end

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [STAT_WIDTH-1:0] words_q, words_d;

            always_comb begin
                words_d = words_q;
                if (req_ready[gi] && (words_q != {STAT_WIDTH{1'b1}})) begin
                    words_d = words_q + STAT_WIDTH'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    words_q <= '0;
                end else begin
                    words_q <= words_d;
                end
            end

            assign stat_words[gi*STAT_WIDTH +: STAT_WIDTH] = words_q;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_wr_arbiter
// Purpose  : Directed self-checking bench for fifo_rr_wr_arbiter
//            (DATA_WIDTH=32, NUM_REQ=4, BURST_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_wr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic         fifo_full;
    logic         fifo_w;
    logic [31:0]  fifo_data;
    logic [1:0]   grant_id;
    logic         busy;

    int n_vec;
    int n_err;

    fifo_rr_wr_arbiter #(
        .DATA_WIDTH (32),
        .NUM_REQ    (4),
        .BURST_LEN  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_w    (fifo_w),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        req_data  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = {4{32'h5555_AAAA}};
        @(negedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (fifo_w !== 1'b0) begin n_err++; $display("FAIL reset_fifo_w got=%b exp=0", fifo_w); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        n_vec++; if (fifo_data !== 32'h0) begin n_err++; $display("FAIL reset_fifo_data got=%h exp=0", fifo_data); end
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
    endtask

    task automatic test_single();
        int       n;
        logic [9:0] pat;
        apply_reset();
        n   = 0;
        pat = '0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            req_valid       = (n < 6) ? 4'b0010 : 4'b0000;
            req_data[63:32] = 32'hA0 + n;
            #1;
            pat[s] = fifo_w;
            if (fifo_w === 1'b1) begin
                n_vec++;
                if (fifo_data !== 32'hA0 + n || grant_id !== 2'd1 || req_ready !== 4'b0010) begin
                    n_err++;
                    $display("FAIL single_word%0d got data=%h id=%0d rdy=%b exp data=%h id=1 rdy=0010",
                             n, fifo_data, grant_id, req_ready, 32'hA0 + n);
                end
                n++;
            end
        end
        n_vec++; if (pat !== 10'b0011011110) begin n_err++; $display("FAIL single_w_pattern got=%b exp=0011011110", pat); end
        n_vec++; if (n != 6) begin n_err++; $display("FAIL single_word_count got=%0d exp=6", n); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_end_busy got=%b exp=0", busy); end
        req_valid = '0;
    endtask

    task automatic test_all_four();
        int cnt[4];
        int order[5];
        int exp_id;
        logic exp_w;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        apply_reset();
        for (int s = 0; s < 25; s++) begin
            @(negedge clk);
            req_valid = 4'hF;
            for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h100 * i + cnt[i];
            #1;
            exp_w  = (s % 5) != 0;
            exp_id = order[s / 5];
            n_vec++;
            if (fifo_w !== exp_w) begin
                n_err++;
                $display("FAIL all4_fifo_w cycle%0d got=%b exp=%b", s, fifo_w, exp_w);
            end
            if (exp_w && fifo_w === 1'b1) begin
                n_vec++;
                if (grant_id !== 2'(exp_id) || req_ready !== (4'b0001 << exp_id) ||
                    fifo_data !== 32'h100 * exp_id + cnt[exp_id]) begin
                    n_err++;
                    $display("FAIL all4_grant cycle%0d got id=%0d rdy=%b data=%h exp id=%0d data=%h",
                             s, grant_id, req_ready, fifo_data, exp_id, 32'h100 * exp_id + cnt[exp_id]);
                end
                cnt[exp_id]++;
            end
        end
        n_vec++; if (cnt[0] != 8 || cnt[1] != 4 || cnt[2] != 4 || cnt[3] != 4) begin
            n_err++; $display("FAIL all4_counts got=%0d,%0d,%0d,%0d exp=8,4,4,4", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        req_valid = '0;
    endtask

    task automatic test_full_stall();
        int   n;
        logic exp_w[9];
        exp_w = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        n = 0;
        for (int s = 0; s < 9; s++) begin
            @(negedge clk);
            req_valid      = (n < 4) ? 4'b0001 : 4'b0000;
            req_data[31:0] = 32'hB0 + n;
            fifo_full      = (s >= 3 && s <= 5);
            #1;
            n_vec++;
            if (fifo_w !== exp_w[s]) begin
                n_err++; $display("FAIL stall_fifo_w cycle%0d got=%b exp=%b", s, fifo_w, exp_w[s]);
            end
            if (s >= 3 && s <= 5) begin
                n_vec++;
                if (req_ready !== 4'b0000 || busy !== 1'b1 || grant_id !== 2'd0) begin
                    n_err++;
                    $display("FAIL stall_hold cycle%0d got rdy=%b busy=%b id=%0d exp rdy=0000 busy=1 id=0",
                             s, req_ready, busy, grant_id);
                end
            end
            if (fifo_w === 1'b1) begin
                n_vec++;
                if (fifo_data !== 32'hB0 + n) begin
                    n_err++; $display("FAIL stall_data word%0d got=%h exp=%h", n, fifo_data, 32'hB0 + n);
                end
                n++;
            end
        end
        n_vec++; if (n != 4) begin n_err++; $display("FAIL stall_word_count got=%0d exp=4", n); end
        fifo_full = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_last();
        int   n2;
        logic exp_w[5];
        exp_w = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        n2 = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            req_valid        = 4'b1100;
            req_data[95:64]  = 32'hC0 + n2;
            req_data[127:96] = 32'hD0;
            req_last         = (n2 == 1) ? 4'b0100 : 4'b0000;
            #1;
            n_vec++;
            if (fifo_w !== exp_w[s]) begin
                n_err++; $display("FAIL last_fifo_w cycle%0d got=%b exp=%b", s, fifo_w, exp_w[s]);
            end
            if (fifo_w === 1'b1 && s <= 2) begin
                n_vec++;
                if (grant_id !== 2'd2 || fifo_data !== 32'hC0 + n2) begin
                    n_err++; $display("FAIL last_req2 cycle%0d got id=%0d data=%h exp id=2 data=%h",
                                      s, grant_id, fifo_data, 32'hC0 + n2);
                end
                n2++;
            end
            if (s == 4) begin
                n_vec++;
                if (grant_id !== 2'd3 || fifo_data !== 32'hD0 || req_ready !== 4'b1000) begin
                    n_err++; $display("FAIL last_next_grant got id=%0d data=%h rdy=%b exp id=3 data=000000d0 rdy=1000",
                                      grant_id, fifo_data, req_ready);
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
        req_last  = '0;
        #1;
        n_vec++; if (fifo_w !== 1'b0) begin n_err++; $display("FAIL last_drop_fifo_w got=%b exp=0", fifo_w); end
    endtask

    task automatic test_drop();
        logic [3:0] vld[5];
        vld = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011};
        apply_reset();
        req_data[31:0]  = 32'hE0;
        req_data[63:32] = 32'hE1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            req_valid = vld[s];
            #1;
            if (s == 1) begin
                n_vec++;
                if (fifo_w !== 1'b1 || grant_id !== 2'd0) begin
                    n_err++; $display("FAIL drop_first got w=%b id=%0d exp w=1 id=0", fifo_w, grant_id);
                end
            end
            if (s == 2) begin
                n_vec++;
                if (fifo_w !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                    n_err++; $display("FAIL drop_abandon got w=%b rdy=%b busy=%b exp w=0 rdy=0000 busy=1",
                                      fifo_w, req_ready, busy);
                end
            end
            if (s == 3) begin
                n_vec++;
                if (busy !== 1'b0 || fifo_w !== 1'b0) begin
                    n_err++; $display("FAIL drop_idle got busy=%b w=%b exp busy=0 w=0", busy, fifo_w);
                end
            end
            if (s == 4) begin
                n_vec++;
                if (grant_id !== 2'd1 || fifo_w !== 1'b1 || req_ready !== 4'b0010 || fifo_data !== 32'hE1) begin
                    n_err++; $display("FAIL drop_next_grant got id=%0d w=%b rdy=%b data=%h exp id=1 w=1 rdy=0010 data=000000e1",
                                      grant_id, fifo_w, req_ready, fifo_data);
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_data = {32'h33, 32'h22, 32'h11, 32'h00};
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            req_valid = 4'b0100;
            #1;
        end
        n_vec++;
        if (fifo_w !== 1'b1 || grant_id !== 2'd2) begin
            n_err++; $display("FAIL areset_pre got w=%b id=%0d exp w=1 id=2", fifo_w, grant_id);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0000 || fifo_w !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            n_err++; $display("FAIL areset_immediate got rdy=%b w=%b busy=%b id=%0d exp rdy=0000 w=0 busy=0 id=0",
                              req_ready, fifo_w, busy, grant_id);
        end
        @(negedge clk);
        req_valid = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (grant_id !== 2'd0 || fifo_w !== 1'b1 || busy !== 1'b1 || fifo_data !== 32'h00) begin
            n_err++; $display("FAIL areset_first_grant got id=%0d w=%b busy=%b data=%h exp id=0 w=1 busy=1 data=0",
                              grant_id, fifo_w, busy, fifo_data);
        end
        req_valid = '0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_full_stall();
        test_last();
        test_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
